// File: rtl/pe_pkg.sv
// Shared widths, psum range limits and the saturating/wrapping add used by the PE.
package pe_pkg;

    localparam int DATA_IN_BW_DEF     = 8;
    localparam int WEIGHT_BW_DEF      = 8;
    localparam int PARTIAL_SUM_BW_DEF = 19;

    typedef struct packed {
        logic        ovf;
        logic [63:0] val;
    } sat_res_t;

    function automatic logic signed [63:0] psum_max(input int bw);
        return (64'sd1 <<< (bw - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] psum_min(input int bw);
        return -(64'sd1 <<< (bw - 1));
    endfunction

    // Operands arrive sign-extended to 64 bits; val holds the result, valid in its low bw bits.
    function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                         input logic signed [63:0] b,
                                         input int                 bw,
                                         input logic               sat);
        logic signed [63:0] full;
        logic signed [63:0] hi_lim;
        logic signed [63:0] lo_lim;
        logic signed [63:0] wrapped;
        sat_res_t           r;
        full    = a + b;
        hi_lim  = psum_max(bw);
        lo_lim  = psum_min(bw);
        wrapped = (full <<< (64 - bw)) >>> (64 - bw);
        r.ovf   = (full > hi_lim) || (full < lo_lim);
        if (!r.ovf)            r.val = full;
        else if (!sat)         r.val = wrapped;
        else if (full > hi_lim) r.val = hi_lim;
        else                   r.val = lo_lim;
        return r;
    endfunction

endpackage

// File: rtl/pe_dbuf_sat_if.sv
// Data, psum and weight-chain signals of one PE; master drives the PE, slave is the PE.
interface pe_dbuf_sat_if #(
    parameter int DATA_IN_BW     = 8,
    parameter int WEIGHT_BW      = 8,
    parameter int PARTIAL_SUM_BW = 19
);
    logic                      is_signed;
    logic                      din_valid;
    logic [DATA_IN_BW-1:0]     DIN;
    logic                      psum_in_valid;
    logic [PARTIAL_SUM_BW-1:0] PSUM_IN;
    logic                      w_shift_en;
    logic [WEIGHT_BW-1:0]      W_IN;
    logic                      w_swap;
    logic                      ovf_clr;
    logic [DATA_IN_BW-1:0]     DF_COL;
    logic                      df_col_valid;
    logic [WEIGHT_BW-1:0]      W_OUT;
    logic [PARTIAL_SUM_BW-1:0] PSUM_OUT;
    logic                      psum_out_valid;
    logic                      ovf;

    modport master (
        output is_signed, din_valid, DIN, psum_in_valid, PSUM_IN,
               w_shift_en, W_IN, w_swap, ovf_clr,
        input  DF_COL, df_col_valid, W_OUT, PSUM_OUT, psum_out_valid, ovf
    );

    modport slave (
        input  is_signed, din_valid, DIN, psum_in_valid, PSUM_IN,
               w_shift_en, W_IN, w_swap, ovf_clr,
        output DF_COL, df_col_valid, W_OUT, PSUM_OUT, psum_out_valid, ovf
    );
endinterface

// File: rtl/pe_weight_dbuf.sv
// Double-buffered weight: shadow shifts down the column chain, active is loaded from shadow on swap.
// Latency 1 cycle for both shift and swap; a same-edge shift+swap moves the pre-edge shadow into active.
module pe_weight_dbuf #(
    parameter int WEIGHT_BW = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 shift_en,
    input  logic                 swap,
    input  logic [WEIGHT_BW-1:0] w_in,
    output logic [WEIGHT_BW-1:0] w_shadow,
    output logic [WEIGHT_BW-1:0] w_active
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_shadow <= '0;
      w_active <= '0;
    end else begin
      if (swap)     w_active <= w_shadow;
      if (shift_en) w_shadow <= w_in;
    end
  end

endmodule

// File: rtl/pe_dbuf_sat.sv
// Weight-stationary systolic PE with double-buffered weight and saturating/wrapping accumulate.
// Latency 1 cycle DIN/PSUM_IN->outputs; no backpressure, validity tags ride alongside the data.
module pe_dbuf_sat
  import pe_pkg::*;
#(
    parameter int DATA_IN_BW     = DATA_IN_BW_DEF,
    parameter int WEIGHT_BW      = WEIGHT_BW_DEF,
    parameter int PARTIAL_SUM_BW = PARTIAL_SUM_BW_DEF,
    parameter int SATURATE       = 1
) (
    input logic         clk,
    input logic         rstn,
    pe_dbuf_sat_if.slave io
);

  localparam int DX_W   = DATA_IN_BW + 1;
  localparam int WX_W   = WEIGHT_BW + 1;
  localparam int PROD_W = DX_W + WX_W;

  logic [WEIGHT_BW-1:0] w_shadow;
  logic [WEIGHT_BW-1:0] w_active;

  pe_weight_dbuf #(.WEIGHT_BW(WEIGHT_BW)) u_wbuf (
      .clk     (clk),
      .rstn    (rstn),
      .shift_en(io.w_shift_en),
      .swap    (io.w_swap),
      .w_in    (io.W_IN),
      .w_shadow(w_shadow),
      .w_active(w_active)
  );

  logic signed [DX_W-1:0]   din_x;
  logic signed [WX_W-1:0]   w_x;
  logic signed [PROD_W-1:0] mul;
  logic signed [PROD_W-1:0] prod;
  logic signed [63:0]       psum_in_x;
  logic signed [63:0]       prod_x;
  sat_res_t                 res;
  logic [63-PARTIAL_SUM_BW:0] res_hi_unused;

  // One extra bit per operand lets a single signed multiplier serve both modes.
  assign din_x = signed'({io.is_signed & io.DIN[DATA_IN_BW-1], io.DIN});
  assign w_x   = signed'({io.is_signed & w_active[WEIGHT_BW-1], w_active});
  assign mul   = din_x * w_x;
  assign prod  = io.din_valid ? mul : '0;

  assign psum_in_x = {{(64 - PARTIAL_SUM_BW){io.PSUM_IN[PARTIAL_SUM_BW-1]}}, io.PSUM_IN};
  assign prod_x    = {{(64 - PROD_W){prod[PROD_W-1]}}, prod};
  assign res       = sat_add(psum_in_x, prod_x, PARTIAL_SUM_BW, SATURATE != 0);
  assign res_hi_unused = res.val[63:PARTIAL_SUM_BW];

  logic [DATA_IN_BW-1:0]     df_col_q;
  logic                      df_col_valid_q;
  logic [PARTIAL_SUM_BW-1:0] psum_out_q;
  logic                      psum_out_valid_q;
  logic                      ovf_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      df_col_q         <= '0;
      df_col_valid_q   <= 1'b0;
      psum_out_q       <= '0;
      psum_out_valid_q <= 1'b0;
      ovf_q            <= 1'b0;
    end else begin
      if (io.din_valid) df_col_q <= io.DIN;
      df_col_valid_q   <= io.din_valid;
      psum_out_q       <= res.val[PARTIAL_SUM_BW-1:0];
      psum_out_valid_q <= io.psum_in_valid;
      // Only overflows on a tagged psum count; set beats a same-cycle clear.
      if (io.psum_in_valid && res.ovf) ovf_q <= 1'b1;
      else if (io.ovf_clr)             ovf_q <= 1'b0;
    end
  end

  assign io.DF_COL         = df_col_q;
  assign io.df_col_valid   = df_col_valid_q;
  assign io.W_OUT          = w_shadow;
  assign io.PSUM_OUT       = psum_out_q;
  assign io.psum_out_valid = psum_out_valid_q;
  assign io.ovf            = ovf_q;

endmodule
